// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//
// Instruction-address generator with an IDLE / RUN / DONE sequencer.
// While running, the next address is chosen with the priority
// stall > halt > branch > increment. All address arithmetic wraps
// silently modulo 2^PC_WIDTH.
//
// Handshake: start is a level request. It is honoured only in IDLE or
// DONE, and is ignored while RUN is active. There is no ready/ack; busy
// and done report the registered state.
//
// Ports
//   clk             in   sole clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   start           in   level request to begin execution
//   stall           in   freeze pc and state this cycle (RUN only)
//   halt            in   current instruction is the halt instruction
//   branch_taken    in   next pc comes from a branch
//   branch_relative in   1 = pc-relative, 0 = absolute branch
//   branch_target   in   absolute branch destination [PC_WIDTH]
//   branch_offset   in   signed relative offset [OFFSET_WIDTH]
//   pc              out  current instruction address (registered)
//   busy            out  high in RUN (registered)
//   done            out  high in DONE (registered)
//   dbg_state_o     out  raw FSM state for debug/observation
// -----------------------------------------------------------------------------
module program_counter #(
   parameter int unsigned         PC_WIDTH     = 10,
   parameter int unsigned         OFFSET_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] START_ADDR   = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stall,
   input  logic                    halt,
   input  logic                    branch_taken,
   input  logic                    branch_relative,
   input  logic [PC_WIDTH-1:0]     branch_target,
   input  logic [OFFSET_WIDTH-1:0] branch_offset,
   output logic [PC_WIDTH-1:0]     pc,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Relative arithmetic is done at the wider of the two widths so a wide
   // offset is not truncated before the add; only the low PC_WIDTH bits
   // of the sum are kept, which gives the modulo-2^PC_WIDTH wrap.
   localparam int unsigned EXT_W = (PC_WIDTH > OFFSET_WIDTH) ? PC_WIDTH : OFFSET_WIDTH;

   state_e              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_d;
   logic                busy_q;
   logic                done_q;
   logic [EXT_W-1:0]    off_ext;
   logic [EXT_W-1:0]    rel_sum;

   // Next address for an un-stalled, non-halting RUN cycle.
   always_comb begin
      off_ext = EXT_W'($signed(branch_offset));
      rel_sum = EXT_W'(pc_q) + off_ext;
      pc_d    = pc_q + PC_WIDTH'(1);
      if (branch_taken) begin
         pc_d = branch_relative ? rel_sum[PC_WIDTH-1:0] : branch_target;
      end
   end

   // Sequencer; busy/done are registered alongside the state so they have
   // no combinational path from any input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= START_ADDR;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               pc_q <= START_ADDR;
               if (start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               // stall freezes everything; halt keeps pc at the halt address
               if (!stall) begin
                  if (halt) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     pc_q <= pc_d;
                  end
               end
            end
            ST_DONE: begin
               if (start) begin
                  state_q <= ST_RUN;
                  pc_q    <= START_ADDR;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               pc_q    <= START_ADDR;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pc          = pc_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

   localparam int PCW   = 10;
   localparam int OFFW  = 8;
   localparam int START = 0;
   localparam int MODV  = 1 << PCW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            start = 1'b0;
   logic            stall = 1'b0;
   logic            halt = 1'b0;
   logic            branch_taken = 1'b0;
   logic            branch_relative = 1'b0;
   logic [PCW-1:0]  branch_target = '0;
   logic [OFFW-1:0] branch_offset = '0;
   logic [PCW-1:0]  pc;
   logic            busy;
   logic            done;
   logic [1:0]      dbg_state;

   int checks = 0;
   int errors = 0;

   program_counter #(
      .PC_WIDTH(PCW),
      .OFFSET_WIDTH(OFFW),
      .START_ADDR(PCW'(START))
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .stall(stall),
      .halt(halt),
      .branch_taken(branch_taken),
      .branch_relative(branch_relative),
      .branch_target(branch_target),
      .branch_offset(branch_offset),
      .pc(pc),
      .busy(busy),
      .done(done),
      .dbg_state_o(dbg_state)
   );

   // ---------------- reference model ----------------
   // "running" / "finished" flags plus an integer address; arithmetic is
   // plain signed integer math folded back into [0, 2^PCW).
   bit m_running = 0;
   bit m_finished = 0;
   int m_pc = START;

   function automatic int wrap(input int x);
      return ((x % MODV) + MODV) % MODV;
   endfunction

   task automatic model_reset();
      m_running  = 0;
      m_finished = 0;
      m_pc       = START;
   endtask

   task automatic model_step();
      if (!m_running) begin
         if (start) begin
            m_running  = 1;
            m_finished = 0;
            m_pc       = START;
         end
      end else if (!stall) begin
         if (halt) begin
            m_running  = 0;
            m_finished = 1;
         end else if (branch_taken && branch_relative) begin
            m_pc = wrap(m_pc + int'($signed(branch_offset)));
         end else if (branch_taken) begin
            m_pc = int'(branch_target);
         end else begin
            m_pc = wrap(m_pc + 1);
         end
      end
   endtask

   // advance one rising edge, update the model, settle away from the edge
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      start = 0; stall = 0; halt = 0;
      branch_taken = 0; branch_relative = 0;
      branch_target = '0; branch_offset = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      model_reset();
      #12;
      checks++;
      if ({pc, busy, done} !== {PCW'(START), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset: pc=%0d busy=%b done=%b expected pc=%0d busy=0 done=0", pc, busy, done, START);
      end
      @(negedge clk);
      rst_n = 1;
      tick();  // idle edge with start=0
      checks++;
      if ({pc, busy, done} !== {PCW'(START), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL idle_wait: pc=%0d busy=%b done=%b expected pc=%0d busy=0 done=0", pc, busy, done, START);
      end
   endtask

   task automatic test_sequence();
      start = 1;
      tick();
      start = 0;
      checks++;
      if ({pc, busy, done} !== {PCW'(START), 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL start_entry: pc=%0d busy=%b done=%b expected pc=0 busy=1 done=0", pc, busy, done);
      end
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if ({pc, busy, done} !== {PCW'(i), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL increment_%0d: pc=%0d busy=%b done=%b expected pc=%0d busy=1 done=0", i, pc, busy, done, i);
         end
      end
   endtask

   task automatic test_branches();
      branch_taken = 1; branch_relative = 0; branch_target = PCW'(20);
      tick();
      branch_relative = 1; branch_offset = 8'hFB;
      tick();
      checks++;
      if (pc !== PCW'(15)) begin
         errors++;
         $display("FAIL rel_branch_back: pc=%0d expected 15", pc);
      end
      branch_relative = 0; branch_target = PCW'(300);
      tick();
      checks++;
      if (pc !== PCW'(300)) begin
         errors++;
         $display("FAIL abs_branch: pc=%0d expected 300", pc);
      end
      branch_relative = 1; branch_offset = 8'h7F;
      tick();
      checks++;
      if (pc !== PCW'(427)) begin
         errors++;
         $display("FAIL rel_branch_fwd: pc=%0d expected 427", pc);
      end
      clear_inputs();
   endtask

   task automatic test_wrap();
      branch_taken = 1; branch_relative = 0; branch_target = PCW'(1023);
      tick();
      branch_taken = 0;
      tick();
      checks++;
      if (pc !== PCW'(0)) begin
         errors++;
         $display("FAIL wrap_up: pc=%0d expected 0", pc);
      end
      branch_taken = 1; branch_target = PCW'(2);
      tick();
      branch_relative = 1; branch_offset = 8'hFC;
      tick();
      checks++;
      if (pc !== PCW'(1022)) begin
         errors++;
         $display("FAIL wrap_down: pc=%0d expected 1022", pc);
      end
      clear_inputs();
   endtask

   task automatic test_priority();
      branch_taken = 1; branch_target = PCW'(7);
      tick();
      stall = 1; halt = 1; branch_taken = 1; branch_relative = 1; branch_offset = 8'h10;
      tick();
      checks++;
      if ({pc, busy, done} !== {PCW'(7), 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL stall_priority: pc=%0d busy=%b done=%b expected pc=7 busy=1 done=0", pc, busy, done);
      end
      stall = 0;
      tick();
      checks++;
      if ({pc, busy, done} !== {PCW'(7), 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL halt_done: pc=%0d busy=%b done=%b expected pc=7 busy=0 done=1", pc, busy, done);
      end
      clear_inputs();
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if ({pc, busy, done} !== {PCW'(7), 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL done_hold: pc=%0d busy=%b done=%b expected pc=7 busy=0 done=1", pc, busy, done);
      end
   endtask

   task automatic test_restart();
      start = 1;
      tick();
      checks++;
      if ({pc, busy, done} !== {PCW'(START), 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL restart: pc=%0d busy=%b done=%b expected pc=%0d busy=1 done=0", pc, busy, done, START);
      end
      for (int i = 1; i <= 3; i++) tick();  // start still held
      checks++;
      if ({pc, busy, done} !== {PCW'(START + 3), 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL start_ignored_in_run: pc=%0d busy=%b expected pc=%0d busy=1", pc, busy, START + 3);
      end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      branch_taken = 1; branch_target = PCW'(40);
      tick();
      clear_inputs();
      #2;
      rst_n = 0;
      model_reset();
      #1;
      checks++;
      if ({pc, busy, done} !== {PCW'(START), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: pc=%0d busy=%b done=%b expected pc=0 busy=0 done=0", pc, busy, done);
      end
      #1;
      rst_n = 1;
      start = 1;  // first edge after release must honour start
      tick();
      start = 0;
      checks++;
      if ({pc, busy, done} !== {PCW'(START), 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL start_after_reset: pc=%0d busy=%b done=%b expected pc=0 busy=1 done=0", pc, busy, done);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         start           = ($urandom_range(0, 3) == 0);
         stall           = ($urandom_range(0, 3) == 0);
         halt            = ($urandom_range(0, 15) == 0);
         branch_taken    = ($urandom_range(0, 2) == 0);
         branch_relative = $urandom_range(0, 1);
         branch_target   = PCW'($urandom_range(0, MODV - 1));
         branch_offset   = OFFW'($urandom_range(0, 255));
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 0;
            model_reset();
            #1;
            rst_n = 1;
         end
         tick();
         checks++;
         if ({pc, busy, done} !== {PCW'(m_pc), m_running, m_finished}) begin
            errors++;
            $display("FAIL random_%0d: pc=%0d busy=%b done=%b expected pc=%0d busy=%b done=%b",
                     n, pc, busy, done, m_pc, m_running, m_finished);
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_branches();
      test_wrap();
      test_priority();
      test_restart();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
